// File: rtl/ofifo.sv
// ----------------------------------------------------------------------------
// ofifo -- output-side deskew buffer for the systolic array.
//
// The partial sums leave the bottom of the array one cycle later for each
// column. Every column therefore has its own circular buffer, written by its
// own strobe. Each read pops one entry from every column at the same time and
// registers the result as one aligned full-width row. Each column tracks its
// own occupancy, and this absorbs the skew between the columns.
//
// Parameters:
//   col    number of array columns (independent lanes)
//   bw     psum width per column
//   DEPTH  entries per column (power of two, >= 2)
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       synchronous, active-high; discards all contents
//   in          column c data on in[bw*(c+1)-1 : bw*c]
//   wr          per-column write strobe
//   rd          pop one row (ignored unless o_valid)
//   out         registered aligned row, same lane mapping as in
//   o_full      some column holds DEPTH entries
//   o_valid     every column holds at least one entry
//   o_overflow  sticky drop flag (only with OFIFO_OVERFLOW_FLAG_EN)
//
// Build option: define OFIFO_OVERFLOW_FLAG_EN to add the o_overflow port.
// ----------------------------------------------------------------------------
module ofifo #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int DEPTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [col*bw-1:0]   in,
    input  logic [col-1:0]      wr,
    input  logic                rd,
    output logic [col*bw-1:0]   out,
    output logic                o_full,
    output logic                o_valid
`ifdef OFIFO_OVERFLOW_FLAG_EN
    ,
    output logic                o_overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [bw-1:0]     r_mem  [col][DEPTH];
    logic [AW-1:0]     r_wptr [col];
    logic [AW-1:0]     r_rptr [col];
    logic [CW-1:0]     r_cnt  [col];
    logic [col*bw-1:0] r_out;

    logic [col-1:0]    w_full;
    logic [col-1:0]    w_empty;
    logic [col-1:0]    w_wr_ok;
    logic              w_valid;
    logic              w_rd_ok;

    // Per-column flags from the registered counts. These are the pre-edge
    // fullness values, so a write to a full column is refused even when the
    // same edge pops that column.
    always_comb begin
        w_full  = {col{1'b0}};
        w_empty = {col{1'b0}};
        w_wr_ok = {col{1'b0}};
        for (int c = 0; c < col; c++) begin
            w_full[c]  = (r_cnt[c] == CNT_FULL);
            w_empty[c] = (r_cnt[c] == CNT_ZERO);
            w_wr_ok[c] = wr[c] & ~w_full[c] & ~reset;
        end
    end

    assign w_valid = ~|w_empty;
    assign w_rd_ok = rd & w_valid & ~reset;

    assign out     = r_out;
    assign o_full  = |w_full;
    assign o_valid = w_valid;

    // Storage array. It is not reset, because the pointers and counts
    // alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (w_wr_ok[c]) begin
                r_mem[c][r_wptr[c]] <= in[bw*c +: bw];
            end
        end
    end

    // Per-column write/read pointers and occupancy counts.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (reset) begin
                r_wptr[c] <= PTR_ZERO;
                r_rptr[c] <= PTR_ZERO;
                r_cnt[c]  <= CNT_ZERO;
            end else begin
                if (w_wr_ok[c]) begin
                    r_wptr[c] <= r_wptr[c] + PTR_ONE;
                end
                if (w_rd_ok) begin
                    r_rptr[c] <= r_rptr[c] + PTR_ONE;
                end
                // A write plus a pop on the same edge leaves the count unchanged.
                case ({w_wr_ok[c], w_rd_ok})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CNT_ONE;
                    2'b01:   r_cnt[c] <= r_cnt[c] - CNT_ONE;
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Aligned output row. It holds its value until the next accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= {(col*bw){1'b0}};
        end else if (w_rd_ok) begin
            for (int c = 0; c < col; c++) begin
                r_out[bw*c +: bw] <= r_mem[c][r_rptr[c]];
            end
        end
    end

`ifdef OFIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky drop indicator. Only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (|(wr & w_full)) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif

endmodule
